// File: rtl/rv_point_pkg.sv
// Shared constants and state encoding for the point-register memory sequencer.
package rv_point_pkg;

    localparam int unsigned BEATS   = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned POINT_W = BEATS * WORD_W;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BEAT_W  = $clog2(BEATS);
    localparam int unsigned LANE_W  = $clog2(POINT_W);

    typedef enum logic {
        IDLE = 1'b0,
        BEAT = 1'b1
    } state_t;

endpackage

// File: rtl/point_mem_seq_if.sv
// Scalar, point and memory-port signals of the point sequencer.
interface point_mem_seq_if;
    import rv_point_pkg::*;

    logic                sc_req;
    logic                sc_we;
    logic [ADDR_W-1:0]   sc_addr;
    logic [WORD_W-1:0]   sc_wdata;
    logic                sc_gnt;
    logic [WORD_W-1:0]   sc_rdata;

    logic                pt_req;
    logic                pt_we;
    logic [ADDR_W-1:0]   pt_addr;
    logic [POINT_W-1:0]  pt_wdata;
    logic                pt_busy;
    logic                pt_done;
    logic                pt_err;
    logic [POINT_W-1:0]  pt_rdata;

    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic                mem_we;
    logic [WORD_W-1:0]   mem_rdata;

    // Sequencer side
    modport slave (
        input  sc_req, sc_we, sc_addr, sc_wdata,
        input  pt_req, pt_we, pt_addr, pt_wdata,
        input  mem_rdata,
        output sc_gnt, sc_rdata,
        output pt_busy, pt_done, pt_err, pt_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    // Core pipeline and memory side
    modport master (
        output sc_req, sc_we, sc_addr, sc_wdata,
        output pt_req, pt_we, pt_addr, pt_wdata,
        output mem_rdata,
        input  sc_gnt, sc_rdata,
        input  pt_busy, pt_done, pt_err, pt_rdata,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/point_mem_seq.sv
// Shares one 32-bit memory port between scalar load/store and 8-beat
// 256-bit point transfers; the point side owns the port while busy.
module point_mem_seq
    import rv_point_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    point_mem_seq_if.slave  bus
);

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                lat_we_q;
    logic [ADDR_W-1:0]   lat_addr_q;
    logic [POINT_W-1:0]  lat_wdata_q;
    logic                pt_busy_q;
    logic                pt_done_q;
    logic                pt_err_q;
    logic [POINT_W-1:0]  pt_rdata_q;

    logic [ADDR_W-1:0]   beat_off;
    logic [LANE_W-1:0]   lane_lo;

    assign beat_off = ADDR_W'({beat_q, 2'b00});
    assign lane_lo  = LANE_W'(beat_q) * LANE_W'(WORD_W);

    assign bus.pt_busy  = pt_busy_q;
    assign bus.pt_done  = pt_done_q;
    assign bus.pt_err   = pt_err_q;
    assign bus.pt_rdata = pt_rdata_q;
    assign bus.sc_rdata = bus.mem_rdata;

    // Port mux: scalar in IDLE, current point beat otherwise; silent in reset
    always_comb begin
        bus.sc_gnt    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        if (rst_n) begin
            if (state_q == IDLE) begin
                if (bus.sc_req) begin
                    bus.sc_gnt    = 1'b1;
                    bus.mem_addr  = bus.sc_addr;
                    bus.mem_wdata = bus.sc_wdata;
                    bus.mem_we    = bus.sc_we;
                end
            end else begin
                bus.mem_addr = lat_addr_q + beat_off;
                if (lat_we_q) begin
                    bus.mem_wdata = lat_wdata_q[lane_lo +: WORD_W];
                    bus.mem_we    = 1'b1;
                end
            end
        end
    end

    // Transfer FSM with registered status and load-data assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            pt_busy_q   <= 1'b0;
            pt_done_q   <= 1'b0;
            pt_err_q    <= 1'b0;
            pt_rdata_q  <= '0;
        end else begin
            pt_done_q <= 1'b0;
            pt_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.pt_req) begin
                        if (bus.pt_addr[1:0] != 2'b00) begin
                            pt_err_q <= 1'b1;
                        end else begin
                            lat_we_q    <= bus.pt_we;
                            lat_addr_q  <= bus.pt_addr;
                            lat_wdata_q <= bus.pt_wdata;
                            beat_q      <= '0;
                            pt_busy_q   <= 1'b1;
                            state_q     <= BEAT;
                        end
                    end
                end
                BEAT: begin
                    if (!lat_we_q) begin
                        pt_rdata_q[lane_lo +: WORD_W] <= bus.mem_rdata;
                    end
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        beat_q    <= '0;
                        pt_busy_q <= 1'b0;
                        pt_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_point_mem_seq.sv
// Self-checking bench for point_mem_seq: scalar vector table, point-transfer
// scoreboard, and hand sequences for contention, misalignment, wrap and reset.
module tb_point_mem_seq;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    point_mem_seq_if bus();

    point_mem_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational-read memory covering byte addresses [7:2]
    logic [31:0] mem [64];
    always_comb bus.mem_rdata = mem[bus.mem_addr[7:2]];
    always_ff @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    typedef struct {
        logic        addr_ok;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_gnt;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    beat_t        beat_q[$];
    logic [255:0] done_q[$];
    logic [255:0] model_rdata;
    beat_t        mb;
    logic [255:0] mexp;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Scoreboard: every busy cycle must match the next expected beat
    always @(negedge clk) begin
        if (rst_n && bus.pt_busy) begin
            total++;
            if (beat_q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected addr=%h we=%b", bus.mem_addr, bus.mem_we);
            end else begin
                mb = beat_q.pop_front();
                if (bus.mem_addr !== mb.addr || bus.mem_we !== mb.we || bus.mem_wdata !== mb.wdata) begin
                    bad++;
                    $display("FAIL beat addr=%h we=%b wdata=%h exp addr=%h we=%b wdata=%h",
                             bus.mem_addr, bus.mem_we, bus.mem_wdata, mb.addr, mb.we, mb.wdata);
                end
            end
            total++;
            if (bus.sc_gnt !== 1'b0) begin
                bad++;
                $display("FAIL sc_gnt_in_beat act=%b exp=0", bus.sc_gnt);
            end
        end
        if (rst_n && bus.pt_done) begin
            total++;
            if (done_q.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected rdata=%h", bus.pt_rdata);
            end else begin
                mexp = done_q.pop_front();
                if (bus.pt_rdata !== mexp) begin
                    bad++;
                    $display("FAIL pt_rdata act=%h exp=%h", bus.pt_rdata, mexp);
                end
            end
            total++;
            if (bus.pt_err !== 1'b0) begin
                bad++;
                $display("FAIL err_with_done act=%b exp=0", bus.pt_err);
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic sc_write(input logic [31:0] addr, input logic [31:0] data);
        bus.sc_req = 1'b1; bus.sc_we = 1'b1; bus.sc_addr = addr; bus.sc_wdata = data;
        #3;
        chk("sc_write_gnt", bus.sc_gnt, 1'b1);
        @(posedge clk); #1;
        bus.sc_req = 1'b0; bus.sc_we = 1'b0;
    endtask

    task automatic do_point(input logic we, input logic [31:0] addr, input logic [255:0] wdata,
                            input logic sc_hold, input logic coincide);
        logic [31:0]  a;
        logic [255:0] exp;
        int           n;
        exp = model_rdata;
        for (int k = 0; k < 8; k++) begin
            a = addr + 32'(4 * k);
            beat_q.push_back('{1'b1, a, we, we ? wdata[32*k +: 32] : 32'h0});
            if (!we) exp[32*k +: 32] = mem[a[7:2]];
        end
        model_rdata = exp;
        done_q.push_back(exp);
        bus.pt_req = 1'b1; bus.pt_we = we; bus.pt_addr = addr; bus.pt_wdata = wdata;
        if (coincide) begin
            #3;
            chk("coincide_gnt", bus.sc_gnt, 1'b1);
            chk("coincide_addr", bus.mem_addr, bus.sc_addr);
            chk("coincide_we", bus.mem_we, bus.sc_we);
        end
        @(posedge clk); #1;
        bus.pt_req = 1'b0;
        if (coincide) begin bus.sc_req = 1'b0; bus.sc_we = 1'b0; end
        if (sc_hold) begin
            bus.sc_req = 1'b1; bus.sc_we = 1'b0; bus.sc_addr = 32'h20;
        end
        n = 1;
        while (!bus.pt_done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pt_done_latency", 256'(n), 256'd9);
        chk("pt_busy_after_done", bus.pt_busy, 1'b0);
        if (sc_hold) begin
            chk("sc_gnt_done_cycle", bus.sc_gnt, 1'b1);
            chk("sc_rdata_done_cycle", bus.sc_rdata, 32'h11111111);
            bus.sc_req = 1'b0;
        end
    endtask

    vec_t         vecs[18];
    logic [255:0] sw;
    logic [255:0] cw;

    initial begin
        total = 0;
        bad = 0;
        model_rdata = '0;
        rst_n = 1'b0;
        bus.sc_req = 1'b1; bus.sc_we = 1'b1; bus.sc_addr = 32'h10; bus.sc_wdata = 32'hFFFF_FFFF;
        bus.pt_req = 1'b0; bus.pt_we = 1'b0; bus.pt_addr = '0; bus.pt_wdata = '0;

        // Scalar vector table: idle, preload words 8..15, read them back
        vecs[0] = '{1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
        for (int k = 0; k < 8; k++) begin
            vecs[1 + k] = '{1'b1, 1'b1, 32'h20 + 32'(4 * k), 32'(k + 1) * 32'h11111111,
                            1'b1, 32'h20 + 32'(4 * k), 1'b1, 1'b0, 32'h0};
            vecs[9 + k] = '{1'b1, 1'b0, 32'h20 + 32'(4 * k), 32'h0,
                            1'b1, 32'h20 + 32'(4 * k), 1'b0, 1'b1, 32'(k + 1) * 32'h11111111};
        end
        vecs[17] = '{1'b0, 1'b1, 32'h44, 32'hDEAD, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};

        #4;
        chk("rst_sc_gnt", bus.sc_gnt, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_pt_busy", bus.pt_busy, 1'b0);
        chk("rst_pt_done", bus.pt_done, 1'b0);
        chk("rst_pt_err", bus.pt_err, 1'b0);
        chk("rst_pt_rdata", bus.pt_rdata, 256'h0);
        @(posedge clk); #1;
        bus.sc_req = 1'b0; bus.sc_we = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            bus.sc_req = vecs[i].req; bus.sc_we = vecs[i].we;
            bus.sc_addr = vecs[i].addr; bus.sc_wdata = vecs[i].wdata;
            #3;
            chk($sformatf("vec%0d_gnt", i), bus.sc_gnt, vecs[i].exp_gnt);
            chk($sformatf("vec%0d_addr", i), bus.mem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_we", i), bus.mem_we, vecs[i].exp_we);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), bus.sc_rdata, vecs[i].exp_rd);
            @(posedge clk); #1;
        end
        bus.sc_req = 1'b0; bus.sc_we = 1'b0;

        // Load, then back-to-back store and reload
        do_point(1'b0, 32'd32, '0, 1'b0, 1'b0);
        chk("load32_value", bus.pt_rdata,
            256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
        for (int k = 0; k < 8; k++) sw[32*k +: 32] = 32'hA5A5A5A5 ^ 32'(k);
        do_point(1'b1, 32'd64, sw, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) chk($sformatf("store_word%0d", 16 + k), mem[16 + k], sw[32*k +: 32]);
        do_point(1'b0, 32'd64, '0, 1'b0, 1'b0);
        chk("reload64_value", bus.pt_rdata, sw);

        // Scalar held against a busy transfer
        do_point(1'b0, 32'd32, '0, 1'b1, 1'b0);

        // Scalar and point requests in the same idle cycle
        bus.sc_req = 1'b1; bus.sc_we = 1'b1; bus.sc_addr = 32'h80; bus.sc_wdata = 32'h12345678;
        do_point(1'b0, 32'd32, '0, 1'b0, 1'b1);
        chk("coincide_mem", mem[32], 32'h12345678);

        // Misaligned request
        bus.pt_req = 1'b1; bus.pt_we = 1'b0; bus.pt_addr = 32'd34;
        @(posedge clk); #1;
        bus.pt_req = 1'b0;
        chk("mis_err", bus.pt_err, 1'b1);
        chk("mis_busy", bus.pt_busy, 1'b0);
        chk("mis_done", bus.pt_done, 1'b0);
        chk("mis_we", bus.mem_we, 1'b0);
        chk("mis_rdata", bus.pt_rdata, model_rdata);
        @(posedge clk); #1;
        chk("mis_err_clear", bus.pt_err, 1'b0);
        chk("mis_busy_idle", bus.pt_busy, 1'b0);

        // Address wrap across 2^32
        for (int k = 0; k < 4; k++) begin
            sc_write(32'(4 * k), 32'hF000_0000 + 32'(k));
            sc_write(32'(240 + 4 * k), 32'hE000_0000 + 32'(k));
        end
        do_point(1'b0, 32'hFFFF_FFF0, '0, 1'b0, 1'b0);
        chk("wrap_value", bus.pt_rdata,
            256'hF0000003_F0000002_F0000001_F0000000_E0000003_E0000002_E0000001_E0000000);

        // Reset during a store after four beats
        for (int k = 0; k < 8; k++) sc_write(32'(96 + 4 * k), 32'h5EED_0000 + 32'(k));
        for (int k = 0; k < 8; k++) cw[32*k +: 32] = 32'hC0DE_0000 + 32'(k);
        for (int k = 0; k < 4; k++) beat_q.push_back('{1'b1, 32'(96 + 4 * k), 1'b1, cw[32*k +: 32]});
        bus.pt_req = 1'b1; bus.pt_we = 1'b1; bus.pt_addr = 32'd96; bus.pt_wdata = cw;
        @(posedge clk); #1;
        bus.pt_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we", bus.mem_we, 1'b0);
        chk("abort_busy", bus.pt_busy, 1'b0);
        chk("abort_done", bus.pt_done, 1'b0);
        chk("abort_err", bus.pt_err, 1'b0);
        chk("abort_rdata", bus.pt_rdata, 256'h0);
        model_rdata = '0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) chk($sformatf("abort_word%0d", 24 + k), mem[24 + k], cw[32*k +: 32]);
        for (int k = 4; k < 8; k++) chk($sformatf("abort_word%0d", 24 + k), mem[24 + k], 32'h5EED_0000 + 32'(k));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", bus.pt_busy, 1'b0);

        chk("beat_queue_empty", 256'(beat_q.size()), 256'd0);
        chk("done_queue_empty", 256'(done_q.size()), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/point_mem_seq.md
Name: point_mem_seq

Overview:
Sequencer and arbiter for the single 32-bit memory port of the rv32i core, shared between the scalar load/store path and the 256-bit point-register path (loadp/storep). A point transfer is split into 8 consecutive word beats at base, base+4, …, base+28. Word k maps to point bits [32k+31:32k]. Scalar accesses are stalled while a point transfer owns the port. Memory read data is combinational: it is valid in the same cycle as mem_addr, as in the core's testbench memory.

Parameters:
BEATS, 8, word beats per point transfer
WORD_W, 32, memory word width; the point width is BEATS*WORD_W = 256

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active low
sc_req  input  1  scalar access request
sc_we  input  1  scalar write enable
sc_addr  input  32  scalar byte address
sc_wdata  input  32  scalar write data
sc_gnt  output  1  scalar access performed this cycle
sc_rdata  output  32  scalar read data (equals mem_rdata)
pt_req  input  1  point transfer request; single-cycle pulse
pt_we  input  1  1 = store point, 0 = load point
pt_addr  input  32  point base byte address
pt_wdata  input  256  store data
pt_busy  output  1  transfer in progress
pt_done  output  1  one-cycle completion pulse
pt_err  output  1  one-cycle misalignment pulse
pt_rdata  output  256  loaded point
mem_addr  output  32  memory byte address
mem_wdata  output  32  memory write data
mem_we  output  1  memory write strobe
mem_rdata  input  32  memory read data

Behaviour:
- Reset (asynchronous, active low) sets: state IDLE, beat count 0, pt_busy 0, pt_done 0, pt_err 0, pt_rdata 0, and all latched request fields 0.
- While rst_n is low, mem_we and sc_gnt are forced to 0.
- States: IDLE, BEAT.
- In IDLE:
  - The port belongs to the scalar side.
  - sc_gnt = sc_req. mem_addr = sc_addr, mem_wdata = sc_wdata, mem_we = sc_req & sc_we.
  - With sc_req=0: mem_addr = 0 and mem_we = 0.
- Point acceptance: on a rising edge where state is IDLE and pt_req is 1:
  - If pt_addr[1:0] != 0: pt_err pulses high for the next cycle, there is no memory access, and state stays IDLE.
  - Otherwise: latch pt_we, pt_addr and pt_wdata; set beat k = 0; go to BEAT; pt_busy = 1.
- Simultaneous sc_req and pt_req in IDLE: the scalar access completes in that cycle, and the point transfer is accepted at the closing edge.
- In BEAT, beat k:
  - mem_addr = base + 4k, modulo 2^32 (the address wraps).
  - Store: mem_wdata = latched word k, mem_we = 1.
  - Load: mem_we = 0, mem_wdata = 0, and at the closing edge pt_rdata[32k+31:32k] <= mem_rdata.
  - sc_gnt = 0 regardless of sc_req. The scalar side holds its request.
  - pt_req is ignored.
- Beat increments each edge. At the edge ending beat BEATS-1: state goes to IDLE, pt_busy goes to 0, and pt_done = 1 for exactly one cycle.
- Latency: accept edge E0, beats in cycles E0..E7, pt_done high in the cycle after E8. That is 9 edges from acceptance to done.
- pt_rdata holds its value until the next load overwrites it. A store does not change pt_rdata.
- A pt_req arriving in the pt_done cycle (state IDLE) is accepted normally. Back-to-back transfers are allowed.
- Reset mid-transfer aborts immediately. Store beats completed before reset remain in memory; no further writes are made. A partially loaded pt_rdata is cleared to 0.
- pt_done and pt_err are never high in the same cycle.

Decomposition:
- Shared package rv_point_pkg holds: BEATS, WORD_W, POINT_W = 256, the state encoding {IDLE, BEAT}, and the beat-counter width $clog2(BEATS).
- No sub-module. The port mux and lane select are small enough to stay inline.

Test Plan:
- Load: memory words 8..15 = 11111111..88888888; pulse pt_req, pt_we=0, pt_addr=32 -> mem_addr steps 32,36,…,60; pt_done 9 edges later; pt_rdata = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111.
- Store, then reload: store pt_wdata = 256'h{8{32'hA5A5A5A5 ^ k}} to base 64 -> memory words 16..23 written in order with mem_we high 8 cycles; a subsequent load from 64 returns the identical 256-bit value.
- Contention: sc_req held high from the cycle after acceptance -> sc_gnt=0 for all 8 beat cycles, then sc_gnt=1 in the pt_done cycle; when sc_req and pt_req coincide in IDLE, scalar is served that cycle and point beats start next.
- Misaligned: pt_addr=34 -> pt_err pulses one cycle, mem_we stays 0, pt_busy stays 0, pt_rdata unchanged.
- Reset mid-store: drop rst_n after beat 3 of a store to base 96 -> words 24..27 updated, words 28..31 untouched, mem_we=0 immediately, all outputs at reset values.
- Wrap: load with pt_addr=32'hFFFFFFF0 -> mem_addr sequence FFFFFFF0, FFFFFFF4, FFFFFFF8, FFFFFFFC, 0, 4, 8, C; pt_done after 8 beats.
